// File: rtl/irq_pkg.sv
// irq_edge_ctrl shared types: register map, ack FSM states,
// and the lowest-index-first priority encoder.
package irq_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_POL    = 2'd2;
  localparam logic [1:0] REG_INFO   = 2'd3;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_HOLD = 1'b1
  } ack_state_t;

  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: synchroniser, history, polarity edge
// detect and pending latch where a new event beats a clear.
module irq_src_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic src_i,
  input  logic pol_i,
  input  logic clr_i,
  output logic event_o,
  output logic pending_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q, hist_d;
  logic pend_q, pend_d;
  logic s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], src_i};
    s       = sync_q[SYNC_STAGES-1];
    hist_d  = s;
    event_o = pol_i ? (s & ~hist_q) : (~s & hist_q);
    pend_d  = event_o | (pend_q & ~clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pend_q <= 1'b0;
    end else if (ce) begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/irq_edge_ctrl.sv
// Edge-triggered interrupt controller with mask, polarity and
// vectored ack. Define IRQ_EDGE_CTRL_OVF_EN for overflow flags.
module irq_edge_ctrl
  import irq_pkg::*;
#(
  parameter int          NSRC        = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  VEC_BASE    = 8'hF8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [NSRC-1:0] src_i,
  input  logic            cpu_wr,
  input  logic            cpu_rd,
  input  logic [1:0]      cpu_addr,
  input  logic [7:0]      cpu_din,
  output logic [7:0]      cpu_dout,
  output logic            irq_o,
  input  logic            int_ack,
  output logic [7:0]      vec_o
);

  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pol_q, pol_d;
  logic [NSRC-1:0] pend, evt, clr;
  logic [7:0]      pend8, act8, ev8, clr8, ack_clr8;
  ack_state_t      state_q, state_d;
  logic            int_ack_q, ack_rise, hit;
  logic            irq_q, irq_d;
  logic            spur_q, spur_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      vec_q, vec_d;
  logic [3:0]      ovf;
  logic            unused_ok;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_src_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .src_i    (src_i[i]),
      .pol_i    (pol_q[i]),
      .clr_i    (clr[i]),
      .event_o  (evt[i]),
      .pending_o(pend[i])
    );
  end

  always_comb begin
    pend8 = '0;
    pend8[NSRC-1:0] = pend;
    act8 = '0;
    act8[NSRC-1:0] = pend & mask_q;
    ev8 = '0;
    ev8[NSRC-1:0] = evt;
    hit = |act8;
    ack_rise = int_ack & ~int_ack_q;
    state_d = state_q;
    vec_d = vec_q;
    idx_d = idx_q;
    spur_d = spur_q;
    ack_clr8 = '0;
    unique case (state_q)
      ACK_IDLE: begin
        if (ack_rise) begin
          state_d = ACK_HOLD;
          if (hit) begin
            idx_d = prio_enc(act8);
            vec_d = {VEC_BASE[7:3], idx_d};
            spur_d = 1'b0;
            ack_clr8[idx_d] = 1'b1;
          end else begin
            vec_d = VEC_BASE | 8'h07;
            spur_d = 1'b1;
          end
        end
      end
      ACK_HOLD: begin
        if (!int_ack) begin
          state_d = ACK_IDLE;
          vec_d = 8'h00;
        end
      end
      default: ;
    endcase
    clr8 = ack_clr8;
    if (cpu_wr && cpu_addr == REG_STATUS) clr8 = clr8 | cpu_din;
    clr = clr8[NSRC-1:0];
    mask_d = mask_q;
    pol_d = pol_q;
    if (cpu_wr && cpu_addr == REG_MASK) mask_d = cpu_din[NSRC-1:0];
    if (cpu_wr && cpu_addr == REG_POL) pol_d = cpu_din[NSRC-1:0];
    irq_d = hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACK_IDLE;
      int_ack_q <= 1'b0;
      mask_q    <= '0;
      pol_q     <= '1;
      irq_q     <= 1'b0;
      vec_q     <= 8'h00;
      idx_q     <= 3'd0;
      spur_q    <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      int_ack_q <= int_ack;
      mask_q    <= mask_d;
      pol_q     <= pol_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      idx_q     <= idx_d;
      spur_q    <= spur_d;
    end
  end

`ifdef IRQ_EDGE_CTRL_OVF_EN
  logic [3:0] ovf_q, ovf_d;

  // A repeat event outranks the clearing INFO write
  always_comb begin
    ovf_d = ovf_q;
    if (cpu_wr && cpu_addr == REG_INFO) ovf_d = '0;
    ovf_d = ovf_d | (ev8[3:0] & pend8[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else if (ce) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 4'h0;
`endif

  always_comb begin
    cpu_dout = 8'h00;
    unique case (1'b1)
      (cpu_addr == REG_STATUS): cpu_dout = pend8;
      (cpu_addr == REG_MASK):   cpu_dout[NSRC-1:0] = mask_q;
      (cpu_addr == REG_POL):    cpu_dout[NSRC-1:0] = pol_q;
      (cpu_addr == REG_INFO):   cpu_dout = {ovf, spur_q, idx_q};
      default: ;
    endcase
  end

  assign irq_o = irq_q;
  assign vec_o = vec_q;
  assign unused_ok = ^{cpu_rd, cpu_din, ev8, clr8};

endmodule

// File: tb/tb_irq_edge_ctrl.sv
// Scoreboard bench for irq_edge_ctrl: stimulus queues expected
// values, a monitor pops and compares them against the outputs.
module tb_irq_edge_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic [3:0] src_i = 4'h0;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic [1:0] cpu_addr = 2'd0;
  logic [7:0] cpu_din = 8'h00;
  logic [7:0] cpu_dout;
  logic       irq_o;
  logic       int_ack = 1'b0;
  logic [7:0] vec_o;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] msk;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  event  chk_ev;
  int    n_vec = 0;
  int    n_bad = 0;

`ifdef IRQ_EDGE_CTRL_OVF_EN
  localparam logic [7:0] OVF_EXP = 8'hC0;
`else
  localparam logic [7:0] OVF_EXP = 8'h00;
`endif

  always #5 clk = ~clk;

  irq_edge_ctrl #(
    .NSRC(4),
    .SYNC_STAGES(2),
    .VEC_BASE(8'hF8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .src_i   (src_i),
    .cpu_wr  (cpu_wr),
    .cpu_rd  (cpu_rd),
    .cpu_addr(cpu_addr),
    .cpu_din (cpu_din),
    .cpu_dout(cpu_dout),
    .irq_o   (irq_o),
    .int_ack (int_ack),
    .vec_o   (vec_o)
  );

  always begin : mon
    item_t      it;
    logic [7:0] act;
    @(chk_ev);
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expected value queued");
    end else begin
      it = sb.pop_front();
      case (it.kind)
        0:       act = cpu_dout;
        1:       act = {7'b0, irq_o};
        default: act = vec_o;
      endcase
      if ((act & it.msk) !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got %02h want %02h", it.name,
                 act & it.msk, it.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input int kind,
                          input logic [1:0] a, input logic [7:0] msk,
                          input logic [7:0] e);
    item_t it;
    it.name = nm;
    it.kind = kind;
    it.msk = msk;
    it.exp = e;
    sb.push_back(it);
    cpu_addr = a;
    cpu_rd = (kind == 0);
    #1;
    -> chk_ev;
    #1;
    cpu_rd = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [1:0] a,
                        input logic [7:0] e);
    expect_v(nm, 0, a, 8'hFF, e);
  endtask

  task automatic chk_irq(input string nm, input logic e);
    expect_v(nm, 1, 2'd0, 8'h01, {7'b0, e});
  endtask

  task automatic chk_vec(input string nm, input logic [7:0] e);
    expect_v(nm, 2, 2'd0, 8'hFF, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_wr = 1'b1;
    cpu_addr = a;
    cpu_din = d;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    rst = 1'b0;
    chk_rd("rst_status", 2'd0, 8'h00);
    chk_rd("rst_mask", 2'd1, 8'h00);
    chk_rd("rst_pol", 2'd2, 8'h0F);
    tick(1);
    chk_rd("rst_info", 2'd3, 8'h00);
    chk_irq("rst_irq", 1'b0);
    chk_vec("rst_vec", 8'h00);

    wr(2'd1, 8'h01);
    wr(2'd2, 8'h01);
    src_i[0] = 1'b1;
    tick(2);
    chk_rd("rise0_early", 2'd0, 8'h00);
    tick(1);
    chk_rd("rise0_pend", 2'd0, 8'h01);
    chk_irq("rise0_irq_lag", 1'b0);
    tick(1);
    chk_irq("rise0_irq", 1'b1);

    src_i[1] = 1'b1;
    tick(4);
    chk_rd("fall1_wrong_edge", 2'd0, 8'h01);
    src_i[1] = 1'b0;
    tick(3);
    chk_rd("fall1_pend", 2'd0, 8'h03);

    wr(2'd0, 8'h01);
    chk_rd("w1c_bit0", 2'd0, 8'h02);
    wr(2'd2, 8'h05);
    src_i[2] = 1'b1;
    tick(3);
    wr(2'd1, 8'h0F);
    chk_rd("pend_06", 2'd0, 8'h06);

    int_ack = 1'b1;
    tick(1);
    chk_vec("ack1_vec", 8'hF9);
    chk_rd("ack1_status", 2'd0, 8'h04);
    chk_irq("ack1_irq", 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_vec("ack1_hold", 8'hF9);
    end
    int_ack = 1'b0;
    tick(1);
    chk_vec("ack1_release", 8'h00);
    chk_irq("ack1_irq_rem", 1'b1);

    int_ack = 1'b1;
    tick(1);
    chk_vec("ack2_vec", 8'hFA);
    chk_rd("ack2_status", 2'd0, 8'h00);
    chk_irq("ack2_irq_lag", 1'b1);
    tick(1);
    chk_irq("ack2_irq_drop", 1'b0);
    int_ack = 1'b0;
    tick(1);
    chk_vec("ack2_release", 8'h00);

    int_ack = 1'b1;
    tick(1);
    chk_vec("spur_vec", 8'hFF);
    expect_v("spur_info", 0, 2'd3, 8'h0F, 8'h0A);
    chk_rd("spur_status", 2'd0, 8'h00);
    int_ack = 1'b0;
    tick(1);
    chk_vec("spur_release", 8'h00);

    src_i[2] = 1'b0;
    tick(3);
    chk_rd("fall2_no_event", 2'd0, 8'h00);
    src_i[2] = 1'b1;
    tick(3);
    chk_rd("rise2_pend", 2'd0, 8'h04);
    src_i[2] = 1'b0;
    tick(3);
    src_i[2] = 1'b1;
    tick(2);
    wr(2'd0, 8'h04);
    chk_rd("set_beats_w1c", 2'd0, 8'h04);
    wr(2'd0, 8'h04);
    chk_rd("w1c_bit2", 2'd0, 8'h00);

    wr(2'd2, 8'h0D);
    src_i[3] = 1'b1;
    tick(3);
    chk_rd("rise3_first", 2'd0, 8'h08);
    src_i[3] = 1'b0;
    tick(3);
    src_i[3] = 1'b1;
    tick(3);
    chk_rd("rise3_merged", 2'd0, 8'h08);
    expect_v("ovf_set", 0, 2'd3, 8'hF0, OVF_EXP);
    wr(2'd3, 8'h00);
    expect_v("ovf_clear", 0, 2'd3, 8'hF0, 8'h00);

    int_ack = 1'b1;
    tick(1);
    chk_vec("ack3_vec", 8'hFB);
    chk_irq("ack3_irq", 1'b1);
    rst = 1'b1;
    int_ack = 1'b0;
    tick(1);
    chk_vec("rst_hold_vec", 8'h00);
    chk_irq("rst_hold_irq", 1'b0);
    chk_rd("rst_hold_status", 2'd0, 8'h00);
    rst = 1'b0;
    tick(2);
    chk_rd("held_high_early", 2'd0, 8'h00);
    tick(1);
    chk_rd("held_high_pend", 2'd0, 8'h0D);
    chk_rd("held_high_mask", 2'd1, 8'h00);
    tick(1);
    chk_irq("held_high_silent", 1'b0);

    tick(2);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d items want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
